// File: rtl/packet_sink_checker.sv
// Packet sink: accepts 13-bit packets over a valid/ready handshake, checks
// even parity and the alternating sequence bit, and buffers good packets
// in a first-word-fall-through FIFO. Bad packets are dropped and counted.
module packet_sink_checker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dd_valid,
  output logic                       dd_ready,
  input  logic [12:0]                packet,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_dest,
  output logic [7:0]                 out_data,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [CNT_W-1:0]           good_cnt,
  output logic [CNT_W-1:0]           par_err_cnt,
  output logic [CNT_W-1:0]           seq_err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [10:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             exp_seq_q, exp_seq_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] par_q, par_d;
  logic [CNT_W-1:0] seq_q, seq_d;

  logic accept, par_ok, seq_ok, push, pop;

  assign dd_ready   = rst && (count_q != FULL);
  assign out_valid  = (count_q != '0);
  assign fifo_count = count_q;
  assign good_cnt    = good_q;
  assign par_err_cnt = par_q;
  assign seq_err_cnt = seq_q;

  assign accept = dd_valid && dd_ready;
  assign par_ok = ~^packet;
  assign seq_ok = (packet[1] == exp_seq_q);
  assign push   = accept && par_ok && seq_ok;
  assign pop    = out_valid && out_ready;

  // Head entry drives the outputs; zero while the FIFO is empty.
  always_comb begin
    out_dest = '0;
    out_data = '0;
    if (out_valid) begin
      out_dest = mem_q[rd_ptr_q][10:8];
      out_data = mem_q[rd_ptr_q][7:0];
    end
  end

  // Next-state: pointers, occupancy, sequence tracking and saturating counters.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    exp_seq_d = exp_seq_q;
    good_d    = good_q;
    par_d     = par_q;
    seq_d     = seq_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    if (accept) begin
      if (!par_ok) begin
        if (par_q != '1) par_d = par_q + 1'b1;
      end else begin
        // Resync to the stream whether or not the sequence bit matched.
        exp_seq_d = ~packet[1];
        if (!seq_ok) begin
          if (seq_q != '1) seq_d = seq_q + 1'b1;
        end else if (good_q != '1) begin
          good_d = good_q + 1'b1;
        end
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      exp_seq_q <= 1'b0;
      good_q    <= '0;
      par_q     <= '0;
      seq_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      exp_seq_q <= exp_seq_d;
      good_q    <= good_d;
      par_q     <= par_d;
      seq_q     <= seq_d;
    end
  end

  // FIFO storage; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q] <= packet[12:2];
  end

endmodule

// File: tb/tb_packet_sink_checker.sv
module tb_packet_sink_checker;

  logic        clk = 1'b0;
  logic        rst, dd_valid, dd_ready, out_valid, out_ready;
  logic [12:0] packet;
  logic [2:0]  out_dest;
  logic [7:0]  out_data;
  logic [2:0]  fifo_count;
  logic [15:0] good_cnt, par_err_cnt, seq_err_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  packet_sink_checker #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .dd_valid(dd_valid), .dd_ready(dd_ready),
    .packet(packet), .out_valid(out_valid), .out_ready(out_ready),
    .out_dest(out_dest), .out_data(out_data), .fifo_count(fifo_count),
    .good_cnt(good_cnt), .par_err_cnt(par_err_cnt), .seq_err_cnt(seq_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, v;
    logic [12:0] pkt;
    logic        ordy;
    logic        rdy, ov;
    logic [2:0]  dest;
    logic [7:0]  data;
    logic [2:0]  cnt;
    logic [15:0] g, pe, se;
  } vec_t;

  vec_t vt[30];

  function automatic logic [12:0] mk(input logic [2:0] d, input logic [7:0] p, input logic s);
    logic [11:0] b;
    b = {d, p, s};
    return {b, ^b};
  endfunction

  function automatic vec_t V(input logic r, input logic v, input logic [12:0] pk, input logic o,
                             input logic rd, input logic ov, input logic [2:0] d, input logic [7:0] da,
                             input logic [2:0] c, input logic [15:0] g, input logic [15:0] pe,
                             input logic [15:0] se);
    vec_t x;
    x.rst = r; x.v = v; x.pkt = pk; x.ordy = o;
    x.rdy = rd; x.ov = ov; x.dest = d; x.data = da; x.cnt = c;
    x.g = g; x.pe = pe; x.se = se;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    // rst v pkt ordy | rdy ov dest data cnt good par seq   (state after the edge)
    vt[0]  = V(0,0,13'h0,0,          0,0,3'd0,8'h00,3'd0, 0,0,0);
    vt[1]  = V(1,0,13'h0,0,          1,0,3'd0,8'h00,3'd0, 0,0,0);
    vt[2]  = V(1,1,13'h1694,1,       1,1,3'd5,8'hA5,3'd1, 1,0,0);
    vt[3]  = V(1,0,13'h0,1,          1,0,3'd0,8'h00,3'd0, 1,0,0);
    vt[4]  = V(0,0,13'h0,0,          0,0,3'd0,8'h00,3'd0, 0,0,0);
    vt[5]  = V(1,1,13'h1695,1,       1,0,3'd0,8'h00,3'd0, 0,1,0);
    vt[6]  = V(1,1,13'h1694,1,       1,1,3'd5,8'hA5,3'd1, 1,1,0);
    vt[7]  = V(1,1,13'h1694,1,       1,0,3'd0,8'h00,3'd0, 1,1,1);
    vt[8]  = V(1,1,mk(3,8'h3C,1),0,  1,1,3'd3,8'h3C,3'd1, 2,1,1);
    vt[9]  = V(1,0,13'h0,1,          1,0,3'd0,8'h00,3'd0, 2,1,1);
    vt[10] = V(1,1,mk(1,8'h11,0),0,  1,1,3'd1,8'h11,3'd1, 3,1,1);
    vt[11] = V(1,1,mk(2,8'h22,1),0,  1,1,3'd1,8'h11,3'd2, 4,1,1);
    vt[12] = V(1,1,mk(3,8'h33,0),0,  1,1,3'd1,8'h11,3'd3, 5,1,1);
    vt[13] = V(1,1,mk(4,8'h44,1),0,  0,1,3'd1,8'h11,3'd4, 6,1,1);
    vt[14] = V(1,1,mk(6,8'h55,0),0,  0,1,3'd1,8'h11,3'd4, 6,1,1);
    vt[15] = V(1,1,mk(6,8'h55,0),1,  1,1,3'd2,8'h22,3'd3, 6,1,1);
    vt[16] = V(1,1,mk(6,8'h55,0),0,  0,1,3'd2,8'h22,3'd4, 7,1,1);
    vt[17] = V(1,0,13'h0,1,          1,1,3'd3,8'h33,3'd3, 7,1,1);
    vt[18] = V(1,0,13'h0,1,          1,1,3'd4,8'h44,3'd2, 7,1,1);
    vt[19] = V(1,1,mk(7,8'h77,1),1,  1,1,3'd6,8'h55,3'd2, 8,1,1);
    vt[20] = V(1,0,13'h0,1,          1,1,3'd7,8'h77,3'd1, 8,1,1);
    vt[21] = V(1,0,13'h0,1,          1,0,3'd0,8'h00,3'd0, 8,1,1);
    vt[22] = V(1,1,mk(0,8'hAA,0),0,  1,1,3'd0,8'hAA,3'd1, 9,1,1);
    vt[23] = V(1,1,mk(1,8'hBB,1),0,  1,1,3'd0,8'hAA,3'd2, 10,1,1);
    vt[24] = V(1,1,mk(2,8'hCC,0),0,  1,1,3'd0,8'hAA,3'd3, 11,1,1);
    vt[25] = V(0,1,mk(5,8'hDD,1),1,  0,0,3'd0,8'h00,3'd0, 0,0,0);
    vt[26] = V(1,1,mk(5,8'hDD,0),0,  1,1,3'd5,8'hDD,3'd1, 1,0,0);
    vt[27] = V(1,1,mk(5,8'hEE,0),0,  1,1,3'd5,8'hDD,3'd1, 1,0,1);
    vt[28] = V(1,1,mk(5,8'hEE,1)^13'h1,0, 1,1,3'd5,8'hDD,3'd1, 1,1,1);
    vt[29] = V(1,1,mk(4,8'hF0,1),0,  1,1,3'd5,8'hDD,3'd2, 2,1,1);

    for (int i = 0; i < 30; i++) begin
      rst = vt[i].rst; dd_valid = vt[i].v; packet = vt[i].pkt; out_ready = vt[i].ordy;
      @(negedge clk);
      chk("dd_ready",    i, 32'(dd_ready),    32'(vt[i].rdy));
      chk("out_valid",   i, 32'(out_valid),   32'(vt[i].ov));
      chk("out_dest",    i, 32'(out_dest),    32'(vt[i].dest));
      chk("out_data",    i, 32'(out_data),    32'(vt[i].data));
      chk("fifo_count",  i, 32'(fifo_count),  32'(vt[i].cnt));
      chk("good_cnt",    i, 32'(good_cnt),    32'(vt[i].g));
      chk("par_err_cnt", i, 32'(par_err_cnt), 32'(vt[i].pe));
      chk("seq_err_cnt", i, 32'(seq_err_cnt), 32'(vt[i].se));
    end

    // Drain the remaining two entries and confirm FIFO order, with a cycle bound.
    begin
      logic [10:0] exp_q[$];
      int unsigned popped;
      exp_q = '{ {3'd5, 8'hDD}, {3'd4, 8'hF0} };
      popped = 0;
      dd_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 8 && out_valid; c++) begin
        chk("drain_head", 100 + c, 32'({out_dest, out_data}), 32'(exp_q[popped]));
        popped++;
        @(negedge clk);
      end
      chk("drain_pops",  200, 32'(popped), 32'd2);
      chk("drain_empty", 201, 32'(fifo_count), 32'd0);
      chk("drain_ready", 202, 32'(dd_ready), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
